// File: rtl/life_vga_scan.sv
// Raster scanner for the Life array: 640x480 sync timing, cell read addressing and
// two-stage pipelined colour/sync output. Define LIFE_VGA_GRID_EN to overlay cell grid lines.
module life_vga_scan #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          CELL_SHIFT = 3,
  parameter int          N_PX       = 64,
  parameter int          N_PY       = 48,
  parameter int          N_PX_BITS  = 6,
  parameter int          N_PY_BITS  = 6,
  parameter int          STATE_BITS = 1,
  parameter logic [11:0] LIVE_RGB   = 12'h0F0,
  parameter logic [11:0] DEAD_RGB   = 12'h000,
  parameter logic [11:0] BG_RGB     = 12'h222
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  output logic [N_PX_BITS-1:0]  adr_x_vga,
  output logic [N_PY_BITS-1:0]  adr_y_vga,
  input  logic [STATE_BITS-1:0] vga_out,
  output logic                  hsync,
  output logic                  vsync,
  output logic [11:0]           rgb,
  output logic                  frame_start,
  output logic                  vblank
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int CELL_MASK = (1 << CELL_SHIFT) - 1;

  logic [HW-1:0] hcnt_reg;
  logic [VW-1:0] vcnt_reg;
  logic [31:0]   h32, v32, cx, cy;
  logic          h_last, v_last;
  logic          visible, in_array, hs_raw, vs_raw;

  logic [N_PX_BITS-1:0] adr_x_reg;
  logic [N_PY_BITS-1:0] adr_y_reg;
  logic                 vis_s1_reg, in_arr_s1_reg, hs_s1_reg, vs_s1_reg;
  logic [11:0]          rgb_reg, rgb_next;
  logic                 hsync_reg, vsync_reg;

`ifdef LIFE_VGA_GRID_EN
  localparam logic [11:0] GRID_RGB = 12'h444;
  logic grid_raw, grid_s1_reg;
`endif

  // Counter comparisons are done at 32 bits so parameter sums never truncate.
  assign h32    = 32'(hcnt_reg);
  assign v32    = 32'(vcnt_reg);
  assign h_last = (h32 == 32'(H_TOTAL - 1));
  assign v_last = (v32 == 32'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt_reg <= '0;
        vcnt_reg <= v_last ? '0 : vcnt_reg + VW'(1);
      end else begin
        hcnt_reg <= hcnt_reg + HW'(1);
      end
    end
  end

  // Stage S0: decode the current raster position.
  always_comb begin
    visible  = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
    cx       = h32 >> CELL_SHIFT;
    cy       = v32 >> CELL_SHIFT;
    in_array = visible && (cx < 32'(N_PX)) && (cy < 32'(N_PY));
    hs_raw   = (h32 >= 32'(H_ACTIVE + H_FP)) && (h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw   = (v32 >= 32'(V_ACTIVE + V_FP)) && (v32 < 32'(V_ACTIVE + V_FP + V_SYNC));
  end

`ifdef LIFE_VGA_GRID_EN
  assign grid_raw = ((h32 & 32'(CELL_MASK)) == 32'd0) || ((v32 & 32'(CELL_MASK)) == 32'd0);
`endif

  // Stage S1: present the cell address to the array and delay the pixel qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_x_reg     <= '0;
      adr_y_reg     <= '0;
      vis_s1_reg    <= 1'b0;
      in_arr_s1_reg <= 1'b0;
      hs_s1_reg     <= 1'b0;
      vs_s1_reg     <= 1'b0;
`ifdef LIFE_VGA_GRID_EN
      grid_s1_reg   <= 1'b0;
`endif
    end else if (pix_en) begin
      adr_x_reg     <= in_array ? cx[N_PX_BITS-1:0] : '0;
      adr_y_reg     <= in_array ? cy[N_PY_BITS-1:0] : '0;
      vis_s1_reg    <= visible;
      in_arr_s1_reg <= in_array;
      hs_s1_reg     <= hs_raw;
      vs_s1_reg     <= vs_raw;
`ifdef LIFE_VGA_GRID_EN
      grid_s1_reg   <= grid_raw;
`endif
    end
  end

  // Colour select uses the array data that answers the S1 address.
  always_comb begin
    rgb_next = 12'h000;
    if (vis_s1_reg) begin
      if (!in_arr_s1_reg)
        rgb_next = BG_RGB;
`ifdef LIFE_VGA_GRID_EN
      else if (grid_s1_reg)
        rgb_next = GRID_RGB;
`endif
      else if (vga_out != '0)
        rgb_next = LIVE_RGB;
      else
        rgb_next = DEAD_RGB;
    end
  end

  // Stage S2: registered colour and active-low syncs, mutually aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_reg   <= 12'h000;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
    end else if (pix_en) begin
      rgb_reg   <= rgb_next;
      hsync_reg <= ~hs_s1_reg;
      vsync_reg <= ~vs_s1_reg;
    end
  end

  assign adr_x_vga   = adr_x_reg;
  assign adr_y_vga   = adr_y_reg;
  assign rgb         = rgb_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = pix_en && !rst && h_last && v_last;
  assign vblank      = (v32 >= 32'(V_ACTIVE));

endmodule

// File: tb/tb_life_vga_scan.sv
// Directed bench for life_vga_scan: default-size instance for pixel/address vectors and
// line timing, plus a shrunken-raster instance for frame, vsync, vblank and reset sequences.
module tb_life_vga_scan;

`ifdef LIFE_VGA_GRID_EN
  localparam bit GRID_ON = 1'b1;
`else
  localparam bit GRID_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, pen_a, vo_a, hs_a, vs_a, fs_a, vb_a;
  logic [5:0]  ax_a, ay_a;
  logic [11:0] rgb_a;
  logic        rst_b, pen_b, vo_b, hs_b, vs_b, fs_b, vb_b;
  logic [0:0]  ax_b, ay_b;
  logic [11:0] rgb_b;

  int mode_a = 0, mode_b = 0, cyc = 0;
  int tick_a = 0, tick_b = 0;
  int n_vec = 0, n_err = 0;

  // Array models: default instance holds one live cell at (3,2); small instance is all live.
  assign vo_a = (ax_a == 6'd3) && (ay_a == 6'd2);
  assign vo_b = 1'b1;

  life_vga_scan dut_a (
    .clk(clk), .rst(rst_a), .pix_en(pen_a), .adr_x_vga(ax_a), .adr_y_vga(ay_a),
    .vga_out(vo_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a),
    .frame_start(fs_a), .vblank(vb_a)
  );

  // 24x16 raster: H 16/2/3/3, V 12/1/2/1; cells cover columns 0..15, rows 0..7.
  life_vga_scan #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .N_PX(2), .N_PY(1), .N_PX_BITS(1), .N_PY_BITS(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(pen_b), .adr_x_vga(ax_b), .adr_y_vga(ay_b),
    .vga_out(vo_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b),
    .frame_start(fs_b), .vblank(vb_b)
  );

  // pix_en generator: mode 1 = every clk, mode 2 = one clk in four.
  initial begin
    pen_a = 1'b0;
    pen_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      pen_a = (mode_a == 1) || (mode_a == 2 && cyc % 4 == 0);
      pen_b = (mode_b == 1) || (mode_b == 2 && cyc % 4 == 0);
    end
  end

  // Enabled-tick counters since reset release; equal to the raster index of each DUT.
  always @(posedge clk) begin
    if (rst_a) tick_a <= 0; else if (pen_a) tick_a <= tick_a + 1;
    if (rst_b) tick_b <= 0; else if (pen_b) tick_b <= tick_b + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tick_a=%0d tick_b=%0d", tick_a, tick_b);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          h;
    int          v;
    int          ax;
    int          ay;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vb;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_a(input int t);
    int g;
    g = 0;
    while (tick_a < t && g < 60000) begin
      step();
      g++;
    end
    if (tick_a != t) begin
      n_err++;
      $display("FAIL reach_a: got tick %0d, want %0d", tick_a, t);
    end
  endtask

  function automatic logic [11:0] grid_or(input logic [11:0] base, input bit on_grid);
    return (GRID_ON && on_grid) ? 12'h444 : base;
  endfunction

  int          t, g, hold_bad, fall1, fall2, rise1;
  int          fs_cnt, fs_t1, fs_t2, hs_low, vs_low, vb_hi, bad;
  logic [11:0] e, p_rgb;
  logic        p_hs, p_pen;
  logic [5:0]  p_ax, p_ay;
  bit          on_grid;

  initial begin
    vecs[0]  = '{0,   0,  0,  0, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{23,  16, 2,  2, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{25,  16, 3,  2, 12'h0F0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{31,  16, 3,  2, 12'h0F0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{33,  16, 4,  2, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{511, 16, 63, 2, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{513, 16, 0,  0, 12'h222, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{600, 16, 0,  0, 12'h222, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{650, 16, 0,  0, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{656, 16, 0,  0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{750, 16, 0,  0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{752, 16, 0,  0, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{24,  17, 3,  2, 12'h0F0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{31,  23, 3,  2, 12'h0F0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{24,  24, 3,  3, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{639, 30, 0,  0, 12'h222, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{641, 30, 0,  0, 12'h000, 1'b1, 1'b1, 1'b0};

    // Reset state of the default instance, pix_en active during reset.
    rst_a = 1'b1;
    rst_b = 1'b1;
    mode_a = 1;
    repeat (4) step();
    chk("rst_rgb", rgb_a, 12'h000);
    chk("rst_hsync", hs_a, 1);
    chk("rst_vsync", vs_a, 1);
    chk("rst_adr_x", ax_a, 0);
    chk("rst_adr_y", ay_a, 0);
    chk("rst_frame_start", fs_a, 0);
    chk("rst_vblank", vb_a, 0);
    rst_a = 1'b0;

    // Table: address one tick after the count, colour/syncs two ticks after.
    for (int i = 0; i < NV; i++) begin
      t = vecs[i].v * 800 + vecs[i].h;
      on_grid = (vecs[i].h < 512) && (vecs[i].v < 384) && (vecs[i].h % 8 == 0 || vecs[i].v % 8 == 0);
      e = grid_or(vecs[i].rgb, on_grid);
      wait_a(t);
      chk($sformatf("v%0d_vblank", i), vb_a, vecs[i].vb);
      wait_a(t + 1);
      chk($sformatf("v%0d_adr_x", i), ax_a, vecs[i].ax);
      chk($sformatf("v%0d_adr_y", i), ay_a, vecs[i].ay);
      wait_a(t + 2);
      chk($sformatf("v%0d_rgb", i), rgb_a, e);
      chk($sformatf("v%0d_hsync", i), hs_a, vecs[i].hs);
      chk($sformatf("v%0d_vsync", i), vs_a, vecs[i].vs);
      $display("vec %0d h=%0d v=%0d adr=(%0d,%0d) rgb=%03h hs=%0b vs=%0b", i,
               vecs[i].h, vecs[i].v, ax_a, ay_a, rgb_a, hs_a, vs_a);
    end

    // Default instance at one-in-four pixel rate: holds between ticks, 3200-clk lines.
    rst_a = 1'b1;
    mode_a = 2;
    repeat (8) step();
    rst_a = 1'b0;
    hold_bad = 0; fall1 = -1; fall2 = -1; rise1 = -1;
    for (int c = 0; c < 7000; c++) begin
      p_hs = hs_a; p_rgb = rgb_a; p_ax = ax_a; p_ay = ay_a; p_pen = pen_a;
      step();
      if (!p_pen && (hs_a != p_hs || rgb_a != p_rgb || ax_a != p_ax || ay_a != p_ay)) hold_bad++;
      if (p_hs && !hs_a) begin
        if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
      end
      if (!p_hs && hs_a && fall1 >= 0 && rise1 < 0) rise1 = c;
    end
    chk("div4_line_period", fall2 - fall1, 3200);
    chk("div4_hsync_width", rise1 - fall1, 384);
    chk("div4_hold", hold_bad, 0);
    $display("div4 line: falls at clk %0d and %0d, rise at %0d", fall1, fall2, rise1);

    // Small raster, pix_en every clk: two full frames of 384 ticks.
    mode_a = 0;
    rst_b = 1'b1;
    mode_b = 1;
    repeat (4) step();
    rst_b = 1'b0;
    fs_cnt = 0; fs_t1 = -1; fs_t2 = -1; hs_low = 0; vs_low = 0; vb_hi = 0; g = 0;
    while (tick_b < 768 && g < 2000) begin
      if (fs_b) begin
        fs_cnt++;
        if (fs_t1 < 0) fs_t1 = tick_b; else if (fs_t2 < 0) fs_t2 = tick_b;
      end
      if (!hs_b) hs_low++;
      if (!vs_b) vs_low++;
      if (vb_b) vb_hi++;
      case (tick_b)
        2:   chk("s_rgb_0_0", rgb_b, grid_or(12'h0F0, 1'b1));
        21:  chk("s_hsync_h19", hs_b, 0);
        23:  chk("s_hsync_h21", hs_b, 1);
        130: begin
          chk("s_rgb_8_5", rgb_b, grid_or(12'h0F0, 1'b1));
          chk("s_adr_x_9_5", ax_b, 1);
          chk("s_adr_y_9_5", ay_b, 0);
        end
        131: chk("s_rgb_9_5", rgb_b, 12'h0F0);
        245: chk("s_rgb_3_10_bg", rgb_b, 12'h222);
        287: chk("s_vblank_line11", vb_b, 0);
        288: chk("s_vblank_line12", vb_b, 1);
        317: begin
          chk("s_rgb_3_13_blank", rgb_b, 12'h000);
          chk("s_vsync_line13", vs_b, 0);
        end
        default: ;
      endcase
      step();
      g++;
    end
    chk("s_frame_start_count", fs_cnt, 2);
    chk("s_frame_start_tick1", fs_t1, 383);
    chk("s_frame_start_tick2", fs_t2, 767);
    chk("s_hsync_low_ticks", hs_low, 96);
    chk("s_vsync_low_ticks", vs_low, 96);
    chk("s_vblank_ticks", vb_hi, 192);
    $display("small frames: frame_start at ticks %0d,%0d hs_low=%0d vs_low=%0d vb=%0d",
             fs_t1, fs_t2, hs_low, vs_low, vb_hi);

    // Mid-frame reset during both sync pulses, then a full frame before frame_start.
    g = 0;
    while (tick_b < 768 + 13 * 24 + 20 && g < 1000) begin
      step();
      g++;
    end
    chk("s_pre_rst_hsync", hs_b, 0);
    chk("s_pre_rst_vsync", vs_b, 0);
    rst_b = 1'b1;
    step();
    chk("s_mid_rst_rgb", rgb_b, 12'h000);
    chk("s_mid_rst_hsync", hs_b, 1);
    chk("s_mid_rst_vsync", vs_b, 1);
    chk("s_mid_rst_adr_x", ax_b, 0);
    chk("s_mid_rst_adr_y", ay_b, 0);
    chk("s_mid_rst_frame_start", fs_b, 0);
    chk("s_mid_rst_vblank", vb_b, 0);
    rst_b = 1'b0;
    fs_t1 = -1; g = 0;
    while (fs_t1 < 0 && g < 2000) begin
      if (fs_b) fs_t1 = tick_b;
      step();
      g++;
    end
    chk("s_post_rst_frame_start_tick", fs_t1, 383);
    $display("mid-frame reset: next frame_start at tick %0d", fs_t1);

    // Small raster at one-in-four: frame_start lasts exactly one clk per frame.
    rst_b = 1'b1;
    mode_b = 2;
    repeat (8) step();
    rst_b = 1'b0;
    fs_cnt = 0; bad = 0; g = 0;
    while (tick_b < 768 && g < 5000) begin
      if (fs_b) fs_cnt++;
      if (fs_b && !pen_b) bad++;
      step();
      g++;
    end
    chk("s_div4_frame_start_clks", fs_cnt, 2);
    chk("s_div4_frame_start_no_pen", bad, 0);
    $display("div4 frames: frame_start clks=%0d", fs_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
